// File: rtl/uart_duplex_cfg.sv
// Full-duplex UART with compile-time frame format.
//   Parameters: CLK_FREQ / BAUD_RATE give the clocks per bit (must be >= 4),
//   DATA_BITS 5..9, PARITY 0 none / 1 even / 2 odd, STOP_BITS 1 or 2.
//   clk, rst          : system clock, asynchronous active-high reset
//   tx_start, tx_data : send request (taken only while TX idle) and payload, LSB first
//   tx, tx_busy, tx_done : serial out (idle high), frame in progress, end-of-frame pulse
//   rx, loopback      : serial in (asynchronous), select internal tx as RX source
//   rx_data, rx_valid, rx_parity_err, rx_frame_err : received payload, update pulse, flags
module uart_duplex_cfg #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int Cpb = CLK_FREQ / BAUD_RATE;
  localparam int CntW = $clog2(Cpb);
  localparam int BitW = 4;
  localparam logic [CntW-1:0] CntLast  = CntW'(Cpb - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Cpb / 2 - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic OddPar = (PARITY == 2);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_wrap;

  assign tx_wrap = (tx_cnt_q == CntLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    if (tx_state_q != TxIdle) begin
      tx_cnt_d = tx_wrap ? '0 : tx_cnt_q + CntW'(1);
    end
    unique case (tx_state_q)
      TxIdle: begin
        // A request landing in the tx_done cycle is dropped, not queued.
        if (tx_start && !tx_done_q) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ OddPar;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_wrap) begin
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_wrap) begin
          if (tx_bit_q == DataLast) begin
            tx_bit_d = '0;
            if (PARITY != 0) begin
              tx_d       = tx_par_q;
              tx_state_d = TxPar;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TxStop;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BitW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TxPar: begin
        if (tx_wrap) begin
          tx_bit_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_wrap) begin
          if (tx_bit_q == StopLast) begin
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
            tx_state_d = TxIdle;
          end else begin
            tx_bit_d = tx_bit_q + BitW'(1);
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop, RxWaitHi} rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 rx_facc_q, rx_facc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_meta_q, rx_line_q;
  logic                 rx_wrap, rx_ferr_now;

  assign rx_wrap     = (rx_cnt_q == CntLast);
  assign rx_ferr_now = rx_facc_q | ~rx_line_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_facc_d  = rx_facc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_state_q inside {RxStart, RxData, RxPar, RxStop}) begin
      rx_cnt_d = rx_wrap ? '0 : rx_cnt_q + CntW'(1);
    end
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_line_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        // Re-check at the start-bit midpoint; a line already back high was a glitch.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_wrap) begin
          rx_shift_d = {rx_line_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DataLast) begin
            rx_bit_d   = '0;
            rx_facc_d  = 1'b0;
            rx_state_d = (PARITY != 0) ? RxPar : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + BitW'(1);
          end
        end
      end
      RxPar: begin
        if (rx_wrap) begin
          rx_pbit_d  = rx_line_q;
          rx_facc_d  = 1'b0;
          rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_wrap) begin
          if (rx_bit_q == StopLast) begin
            rx_data_d  = rx_shift_q;
            rx_perr_d  = (PARITY != 0) && (rx_pbit_q != ((^rx_shift_q) ^ OddPar));
            rx_ferr_d  = rx_ferr_now;
            rx_valid_d = 1'b1;
            // A low stop bit may be a break; wait for the line to idle before rearming.
            rx_state_d = rx_ferr_now ? RxWaitHi : RxIdle;
          end else begin
            rx_bit_d  = rx_bit_q + BitW'(1);
            rx_facc_d = rx_ferr_now;
          end
        end
      end
      RxWaitHi: begin
        if (rx_line_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_line_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= loopback ? tx_q : rx;
      rx_line_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_facc_q  <= rx_facc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_duplex_cfg.sv
// Bench for uart_duplex_cfg: three instances (8N1, 8E1, 5O2) at 1 MHz / 9600 baud,
// randomized frames checked bit-by-bit against a frame model built from the format rules.
module tb_uart_duplex_cfg;

  localparam int Cpb = 1000000 / 9600;

  logic       clk = 1'b0;
  logic       rst;
  logic       loopback;
  logic [8:0] tx_data;
  logic [2:0] tx_start_v;
  logic [2:0] rx_v;
  logic [2:0] tx_v, tx_busy_v, tx_done_v, rx_valid_v, rx_perr_v, rx_ferr_v;
  logic [7:0] rx_data0, rx_data1;
  logic [4:0] rx_data2;
  logic [8:0] rx_data_w [3];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt [3];
  int valid_cnt [3];
  logic [8:0] exp_data [3];
  logic       exp_perr [3];
  logic       exp_ferr [3];

  always #5 clk = ~clk;

  assign rx_data_w[0] = {1'b0, rx_data0};
  assign rx_data_w[1] = {1'b0, rx_data1};
  assign rx_data_w[2] = {4'b0, rx_data2};

  uart_duplex_cfg u_8n1 (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[0]), .tx_data(tx_data[7:0]),
    .tx(tx_v[0]), .tx_busy(tx_busy_v[0]), .tx_done(tx_done_v[0]), .rx(rx_v[0]),
    .loopback(loopback), .rx_data(rx_data0), .rx_valid(rx_valid_v[0]),
    .rx_parity_err(rx_perr_v[0]), .rx_frame_err(rx_ferr_v[0])
  );

  uart_duplex_cfg #(.PARITY(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[1]), .tx_data(tx_data[7:0]),
    .tx(tx_v[1]), .tx_busy(tx_busy_v[1]), .tx_done(tx_done_v[1]), .rx(rx_v[1]),
    .loopback(loopback), .rx_data(rx_data1), .rx_valid(rx_valid_v[1]),
    .rx_parity_err(rx_perr_v[1]), .rx_frame_err(rx_ferr_v[1])
  );

  uart_duplex_cfg #(.DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) u_5o2 (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[2]), .tx_data(tx_data[4:0]),
    .tx(tx_v[2]), .tx_busy(tx_busy_v[2]), .tx_done(tx_done_v[2]), .rx(rx_v[2]),
    .loopback(loopback), .rx_data(rx_data2), .rx_valid(rx_valid_v[2]),
    .rx_parity_err(rx_perr_v[2]), .rx_frame_err(rx_ferr_v[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ frame model
  function automatic int cfg_bits(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic int cfg_par(input int i);
    return i;  // instance 0 none, 1 even, 2 odd
  endfunction

  function automatic int cfg_stops(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] payload(input int i, input logic [8:0] d);
    int m;
    m = (1 << cfg_bits(i)) - 1;
    return d & m[8:0];
  endfunction

  function automatic logic parity_of(input int i, input logic [8:0] d);
    int ones;
    ones = $countones(payload(i, d));
    return (cfg_par(i) == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  function automatic int frame_len(input int i);
    return 1 + cfg_bits(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stops(i);
  endfunction

  function automatic logic model_bit(input int i, input logic [8:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= cfg_bits(i)) return d[k-1];
    if (cfg_par(i) != 0 && k == cfg_bits(i) + 1) return parity_of(i, d);
    return 1'b1;
  endfunction

  // ------------------------------------------------------------ monitor
  initial begin
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      valid_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (tx_done_v[i] === 1'b1) done_cnt[i]++;
        if (rx_valid_v[i] === 1'b1) begin
          valid_cnt[i]++;
          check_eq($sformatf("u%0d rx_data", i), rx_data_w[i], exp_data[i]);
          check_eq($sformatf("u%0d rx_parity_err", i), rx_perr_v[i], exp_perr[i]);
          check_eq($sformatf("u%0d rx_frame_err", i), rx_ferr_v[i], exp_ferr[i]);
        end
      end
    end
  end

  // Called at the first negedge after the edge that should have dropped tx.
  task automatic check_tx_frame(input int i, input logic [8:0] d, input bit poke);
    int n;
    n = frame_len(i);
    check_eq($sformatf("u%0d tx falls", i), tx_v[i], 1'b0);
    check_eq($sformatf("u%0d tx_busy set", i), tx_busy_v[i], 1'b1);
    repeat (Cpb / 2) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("u%0d tx bit %0d", i, k), tx_v[i], model_bit(i, d, k));
      if (k < n - 1) repeat (Cpb) @(negedge clk);
    end
    repeat (Cpb - Cpb / 2 - 1) @(negedge clk);
    check_eq($sformatf("u%0d tx_done early", i), tx_done_v[i], 1'b0);
    check_eq($sformatf("u%0d tx_busy held", i), tx_busy_v[i], 1'b1);
    @(negedge clk);
    check_eq($sformatf("u%0d tx_done at %0d clocks", i, n * Cpb), tx_done_v[i], 1'b1);
    check_eq($sformatf("u%0d tx_busy drop", i), tx_busy_v[i], 1'b0);
    if (poke) tx_start_v[i] = 1'b1;
    @(negedge clk);
    tx_start_v[i] = 1'b0;
    check_eq($sformatf("u%0d tx_done one cycle", i), tx_done_v[i], 1'b0);
    repeat (3) @(negedge clk);
    check_eq($sformatf("u%0d tx idle after frame", i), tx_v[i], 1'b1);
    check_eq($sformatf("u%0d tx_busy idle", i), tx_busy_v[i], 1'b0);
  endtask

  task automatic run_frame(input logic [8:0] d, input bit lb, input bit busy_poke,
                           input bit done_poke);
    int d0 [3];
    int v0 [3];
    loopback = lb;
    for (int i = 0; i < 3; i++) begin
      exp_data[i] = payload(i, d);
      exp_perr[i] = 1'b0;
      exp_ferr[i] = 1'b0;
      d0[i] = done_cnt[i];
      v0[i] = valid_cnt[i];
    end
    @(negedge clk);
    tx_data = d;
    tx_start_v = 3'b111;
    @(negedge clk);
    tx_start_v = 3'b000;
    tx_data = 9'($urandom);
    fork
      check_tx_frame(0, d, done_poke);
      check_tx_frame(1, d, 1'b0);
      check_tx_frame(2, d, 1'b0);
      begin
        if (busy_poke) begin
          repeat ($urandom_range(50, 800)) @(negedge clk);
          tx_data = 9'($urandom);
          tx_start_v = 3'b111;
          @(negedge clk);
          tx_start_v = 3'b000;
        end
      end
    join
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d single tx_done", i), done_cnt[i] - d0[i], 1);
      check_eq($sformatf("u%0d rx_valid count", i), valid_cnt[i] - v0[i], lb ? 1 : 0);
      check_eq($sformatf("u%0d tx_busy after", i), tx_busy_v[i], 1'b0);
    end
  endtask

  // Drives an externally generated frame onto rx of instance i.
  task automatic send_rx(input int i, input logic [8:0] d, input bit bad_par,
                         input int stop_low);
    @(negedge clk);
    rx_v[i] = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int j = 0; j < cfg_bits(i); j++) begin
      rx_v[i] = d[j];
      repeat (Cpb) @(negedge clk);
    end
    if (cfg_par(i) != 0) begin
      rx_v[i] = parity_of(i, d) ^ bad_par;
      repeat (Cpb) @(negedge clk);
    end
    if (stop_low > 0) begin
      rx_v[i] = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rx_v[i] = 1'b1;
    repeat (Cpb * cfg_stops(i)) @(negedge clk);
  endtask

  task automatic rx_case(input int i, input logic [8:0] d, input bit bad_par,
                         input int stop_low, input int tail);
    int v0;
    exp_data[i] = payload(i, d);
    exp_perr[i] = bad_par && (cfg_par(i) != 0);
    exp_ferr[i] = (stop_low > 0);
    v0 = valid_cnt[i];
    send_rx(i, d, bad_par, stop_low);
    repeat (tail) @(negedge clk);
    check_eq($sformatf("u%0d ext rx_valid count", i), valid_cnt[i] - v0, 1);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int v0;
    int d0 [3];
    int v1 [3];
    rst = 1'b1;
    loopback = 1'b0;
    tx_data = '0;
    tx_start_v = '0;
    rx_v = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d reset tx", i), tx_v[i], 1'b1);
      check_eq($sformatf("u%0d reset tx_busy", i), tx_busy_v[i], 1'b0);
      check_eq($sformatf("u%0d reset tx_done", i), tx_done_v[i], 1'b0);
      check_eq($sformatf("u%0d reset rx_data", i), rx_data_w[i], 0);
      check_eq($sformatf("u%0d reset rx_valid", i), rx_valid_v[i], 1'b0);
      check_eq($sformatf("u%0d reset parity_err", i), rx_perr_v[i], 1'b0);
      check_eq($sformatf("u%0d reset frame_err", i), rx_ferr_v[i], 1'b0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed formats, then randomized frames with start requests during busy/done.
    run_frame(9'h0A5, 1'b1, 1'b0, 1'b0);
    run_frame(9'h007, 1'b1, 1'b1, 1'b1);
    run_frame(9'h03C, 1'b1, 1'b0, 1'b0);
    run_frame(9'h015, 1'b1, 1'b1, 1'b0);
    run_frame(9'h0A5, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      run_frame(9'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    // External RX: directed parity error, then random frames with random parity faults.
    loopback = 1'b0;
    rx_case(1, 9'h05A, 1'b1, 0, 10);
    for (int t = 0; t < 6; t++) begin
      int i;
      i = $urandom_range(0, 2);
      rx_case(i, 9'($urandom), 1'($urandom_range(0, 1)), 0, 10);
    end

    // Stop bit held low: one flagged frame, nothing more until the line idles.
    rx_case(0, 9'h055, 1'b0, 300, 1200);
    rx_case(0, 9'h0C3, 1'b0, 0, 10);

    // Short low glitch is rejected; receiver still takes the next frame.
    v0 = valid_cnt[0];
    @(negedge clk);
    rx_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("u0 glitch no rx_valid", valid_cnt[0] - v0, 0);
    rx_case(0, 9'h03C, 1'b0, 0, 10);

    // Reset 400 clocks into a looped-back frame.
    loopback = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0[i] = done_cnt[i];
      v1[i] = valid_cnt[i];
    end
    @(negedge clk);
    tx_data = 9'h1FF;
    tx_start_v = 3'b111;
    @(negedge clk);
    tx_start_v = 3'b000;
    repeat (400) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d rst tx immediate", i), tx_v[i], 1'b1);
      check_eq($sformatf("u%0d rst tx_busy immediate", i), tx_busy_v[i], 1'b0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d rst rx_data", i), rx_data_w[i], 0);
      check_eq($sformatf("u%0d rst frame_err", i), rx_ferr_v[i], 1'b0);
    end
    rst = 1'b0;
    repeat (3 * Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("u%0d aborted no tx_done", i), done_cnt[i] - d0[i], 0);
      check_eq($sformatf("u%0d aborted no rx_valid", i), valid_cnt[i] - v1[i], 0);
    end
    run_frame(9'h081, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_duplex_cfg.md
UART_DUPLEX_CFG -- requirements
Module: uart_duplex_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate; CPB = CLK_FREQ/BAUD_RATE (integer division), 104 at defaults; CPB >= 4 SHALL hold.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..9.
REQ-004 Parameter PARITY, default 0, 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 tx_start  input  1  request to send tx_data; sampled only while TX is idle.
REQ-009 tx_data  input  DATA_BITS  frame payload, LSB sent first.
REQ-010 tx  output  1  serial line out, idle high.
REQ-011 tx_busy  output  1  TX frame in progress.
REQ-012 tx_done  output  1  one-cycle pulse at frame end.
REQ-013 rx  input  1  serial line in, asynchronous to clk.
REQ-014 loopback  input  1  1 = RX path takes internal tx instead of rx; quasi-static, changed only while both FSMs are idle.
REQ-015 rx_data  output  DATA_BITS  last received payload, held until the next rx_valid.
REQ-016 rx_valid  output  1  one-cycle pulse: rx_data and error flags updated.
REQ-017 rx_parity_err  output  1  parity mismatch on the frame flagged by rx_valid; 0 when PARITY = 0.
REQ-018 rx_frame_err  output  1  any stop bit sampled low on the frame flagged by rx_valid.

Function
REQ-019 TX FSM states IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY = 0.
REQ-020 In IDLE, tx_start high SHALL latch tx_data; on the next clock tx goes 0 and tx_busy goes 1.
REQ-021 Each bit (start, DATA_BITS data, optional parity, STOP_BITS stop) SHALL hold tx for exactly CPB clocks via a bit counter reloaded per bit.
REQ-022 Parity bit = XOR of data bits (even) or its inverse (odd).
REQ-023 Stop bits drive tx = 1; after the last stop bit's CPB clocks, tx_done pulses one cycle, tx_busy drops the same cycle, FSM returns to IDLE.
REQ-024 tx_start while tx_busy = 1 SHALL be ignored (not queued); tx_start in the tx_done cycle is also ignored.
REQ-025 RX input SHALL pass a 2-flop synchronizer (reset value 1) before use.
REQ-026 RX FSM states IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-027 IDLE -> START on synchronized line = 0; START counts CPB/2 clocks, then: line 0 -> DATA, line 1 -> IDLE (glitch rejection, no outputs).
REQ-028 DATA/PAR/STOP SHALL sample the line every CPB clocks after the start mid-point, shifting data LSB first.
REQ-029 On the last stop sample: rx_data, rx_parity_err, rx_frame_err update and rx_valid pulses one cycle later; flags hold until the next rx_valid.
REQ-030 If any stop sample = 0, rx_valid still pulses with rx_frame_err = 1 and FSM enters WAIT_HI, returning to IDLE only after line = 1 is sampled.
REQ-031 TX and RX operate fully concurrently; loopback does not alter tx.

Reset
REQ-032 rst high SHALL immediately force tx = 1, tx_busy = 0, tx_done = 0, rx_data = 0, rx_valid = 0, both error flags = 0, all counters 0, both FSMs IDLE.
REQ-033 Reset mid-frame SHALL abort the frame with no tx_done/rx_valid; the first frame after release behaves as from power-up.

Verification
REQ-034 Defaults 8N1, tx_start with tx_data = 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 104 clocks; tx_done 1040 clocks after tx falls.
REQ-035 PARITY = 1, tx_data = 0x07 -> parity bit 1; PARITY = 2 same data -> parity bit 0; frame 11 bits, tx_done at 1144 clocks.
REQ-036 loopback = 1, send 0x3C -> rx_valid pulse, rx_data = 0x3C, both error flags 0; repeat with DATA_BITS = 5, data 0x15 -> rx_data = 0x15.
REQ-037 rx driven with 0x55 but stop bit held low 300 clocks -> rx_valid with rx_frame_err = 1, rx_data = 0x55; no new frame accepted until rx returns high.
REQ-038 rx low pulse of 30 clocks -> no rx_valid, RX back in IDLE; second tx_start during busy frame -> ignored, single tx_done.
REQ-039 rst asserted 400 clocks into a TX frame -> tx = 1 same cycle, tx_busy = 0, no tx_done; subsequent 0x81 frame transmits correctly.
